vga_fb_arbiter: RTL and testbench

Frame-buffer access scheduler between the VGA timing generator and a single-port synchronous frame memory. Prefetches pixels in raster order into a small FIFO so scan-out never waits, and hands every cycle the display does not need to a host write port with a valid/ready handshake. Sits between the timing generator (`disp_ena`, `frame_start`), the frame RAM, and the host/drawing engine.

---
 rtl/vga_fb_arbiter.sv | 133 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer access scheduler between VGA scan-out and host writes
//
// Prefetches pixels in raster order into a DEPTH-entry FIFO so scan-out never
// waits on memory. Every cycle the display does not need is given to the host
// write port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   disp_ena, frame_start    timing generator strobes
//   host_valid/addr/data     host write request (held stable until host_ready)
//   host_ready               write accepted and committed this cycle (comb)
//   mem_en/we/addr/wdata     single-port synchronous RAM request (comb)
//   mem_rdata                RAM read data, valid the cycle after a read
//   pix_data                 registered pixel to the DAC
//   underflow                sticky: display wanted a pixel while the FIFO was empty
module vga_fb_arbiter #(
  parameter int H_PIXELS = 500,
  parameter int V_PIXELS = 250,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_ena,
  input  logic              frame_start,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow
);

  localparam int TOTAL = H_PIXELS * V_PIXELS;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [CW:0]       DEPTH_C   = (CW + 1)'(DEPTH);

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_addr;

  logic              pop;
  logic              push;
  logic              rd_go;
  logic [CW:0]       occ_after;

  assign pop  = disp_ena && (count != '0);
  assign push = inflight && !frame_start;

  // Occupancy counts the in-flight read as already stored, so issuing a read
  // only when this stays below DEPTH means its data always has a slot.
  always_comb begin
    occ_after = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  end

  assign rd_go = !frame_start && (occ_after < DEPTH_C);

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_ready = 1'b0;
    if (!rst && !frame_start) begin
      if (rd_go) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end else if (host_valid) begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = host_addr;
        mem_wdata  = host_data;
        host_ready = 1'b1;
      end
    end
  end

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      fetch_addr <= '0;
      pix_data   <= '0;
      underflow  <= 1'b0;
    end else begin
      pix_data <= pop ? fifo_mem[rd_ptr] : '0;
      if (disp_ena && (count == '0)) begin
        underflow <= 1'b1;
      end
      if (frame_start) begin
        // Flush; the read returning this cycle (if any) is dropped.
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        inflight   <= 1'b0;
        fetch_addr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count    <= count + CW'(push) - CW'(pop);
        inflight <= rd_go;
        if (rd_go) begin
          fetch_addr <= (fetch_addr == LAST_ADDR) ? '0 : fetch_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  localparam int H_PIXELS = 8;
  localparam int V_PIXELS = 4;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int TOTAL    = H_PIXELS * V_PIXELS;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_ena;
  logic              frame_start;
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;

  int n_checks = 0;
  int n_fail   = 0;

  vga_fb_arbiter #(
    .H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .disp_ena(disp_ena), .frame_start(frame_start),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // RAM model: each word holds the low byte of its address.
  always_ff @(posedge clk) begin
    if (mem_en && !mem_we) begin
      mem_rdata <= mem_addr[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    disp_ena = 1'b0;
    frame_start = 1'b0;
    host_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    disp_ena = 1'b0;
    frame_start = 1'b0;
    host_valid = 1'b0;
    host_addr = '0;
    host_data = '0;
    repeat (3) @(negedge clk);

    // Outputs quiet during reset even with a pending host request.
    host_valid = 1'b1;
    host_addr = 17'h55;
    host_data = 8'h33;
    #1;
    check("rst_host_ready", 32'(host_ready), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_pix", 32'(pix_data), 0);
    check("rst_underflow", 32'(underflow), 0);
    host_valid = 1'b0;

    // Fill after reset: reads of 0..3, then idle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("fill_en0", 32'(mem_en), 1);
    check("fill_addr0", 32'(mem_addr), 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      check("fill_en", 32'(mem_en), 1);
      check("fill_we", 32'(mem_we), 0);
      check("fill_addr", 32'(mem_addr), 32'(k));
    end
    @(negedge clk); #1;
    check("fill_idle", 32'(mem_en), 0);

    // Host write once the FIFO is full.
    @(negedge clk);
    host_valid = 1'b1;
    host_addr = 17'h100;
    host_data = 8'hA5;
    #1;
    check("hw_ready", 32'(host_ready), 1);
    check("hw_we", 32'(mem_we), 1);
    check("hw_addr", 32'(mem_addr), 32'h100);
    check("hw_wdata", 32'(mem_wdata), 32'hA5);
    @(negedge clk);
    host_valid = 1'b0;
    #1;
    check("hw_idle", 32'(mem_en), 0);

    // Eight active pixels with the host starved; host gets the next free cycle.
    host_addr = 17'h101;
    host_data = 8'h5A;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      disp_ena = (k < 8);
      host_valid = 1'b1;
      if (k > 0) check("disp_pix", 32'(pix_data), 32'(k - 1));
      #1;
      check("disp_host_ready", 32'(host_ready), (k == 8) ? 1 : 0);
      if (k < 8) check("disp_rd_addr", 32'(mem_addr), 32'(4 + k));
    end
    @(negedge clk);
    host_valid = 1'b0;
    disp_ena = 1'b0;
    check("disp_pix_off", 32'(pix_data), 0);
    check("disp_underflow", 32'(underflow), 0);

    // frame_start with two stored entries and a read in flight.
    do_reset();
    rst = 1'b0;
    #1;
    check("rst_restart_addr", 32'(mem_addr), 0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    host_valid = 1'b1;
    #1;
    check("fs_no_access", 32'(mem_en), 0);
    check("fs_host_ready", 32'(host_ready), 0);
    @(negedge clk);
    frame_start = 1'b0;
    host_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fs_refill_en", 32'(mem_en), 1);
      check("fs_refill_addr", 32'(mem_addr), 32'(k));
      @(negedge clk);
    end
    #1;
    check("fs_refill_done", 32'(mem_en), 0);
    @(negedge clk);
    disp_ena = 1'b1;
    @(negedge clk);
    disp_ena = 1'b1;
    check("fs_pix0", 32'(pix_data), 0);
    @(negedge clk);
    disp_ena = 1'b0;
    check("fs_pix1", 32'(pix_data), 1);
    @(negedge clk);
    check("fs_underflow", 32'(underflow), 0);

    // Underflow on the first cycle after reset, sticky until reset.
    do_reset();
    rst = 1'b0;
    disp_ena = 1'b1;
    #1;
    check("uf_before", 32'(underflow), 0);
    @(negedge clk);
    disp_ena = 1'b0;
    check("uf_set", 32'(underflow), 1);
    check("uf_pix", 32'(pix_data), 0);
    repeat (3) begin
      @(negedge clk);
      check("uf_sticky", 32'(underflow), 1);
    end

    // Address wrap from TOTAL-1 to 0 in a continuous stream.
    do_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      disp_ena = 1'b1;
      if (k > 0) check("wrap_pix", 32'(pix_data), 32'((k - 1) % TOTAL));
      #1;
      check("wrap_en", 32'(mem_en), 1);
      check("wrap_addr", 32'(mem_addr), 32'((4 + k) % TOTAL));
    end
    @(negedge clk);
    disp_ena = 1'b0;
    check("wrap_underflow", 32'(underflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
